// File: rtl/search_pkg.sv
// Shared types and helpers for the search datapath result trackers.
// Entry fields are held at a fixed maximum width; users zero-extend into them.
package search_pkg;

  localparam int SEQ_MAXW = 32;
  localparam int E_MAXW   = 32;

  localparam logic [E_MAXW-1:0] E_MAX = '1;

  typedef struct packed {
    logic [SEQ_MAXW-1:0] seq;
    logic [E_MAXW-1:0]   e;
    logic                valid;
  } entry_t;

  localparam entry_t ENTRY_RST = '{seq: '0, e: E_MAX, valid: 1'b0};

  // An empty slot loses to any live candidate, even one at E_MAX.
  function automatic logic entry_better(entry_t cand, entry_t slot);
    return cand.valid && (!slot.valid || (cand.e < slot.e));
  endfunction

endpackage

// File: rtl/topk_slot.sv
// One register of the sorted top-K table.
// Either holds, takes the left neighbour (shift), or takes the candidate.
import search_pkg::*;

module topk_slot (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_clear,
  input  logic   i_load,
  input  logic   i_left_better,
  input  logic   i_own_better,
  input  entry_t i_cand,
  input  entry_t i_left,
  output entry_t o_q
);

  entry_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= ENTRY_RST;
    end else if (i_clear) begin
      r_q <= ENTRY_RST;
    end else if (i_load) begin
      if (i_left_better) begin
        r_q <= i_left;
      end else if (i_own_better) begin
        r_q <= i_cand;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/optimum_sequence_topk.sv
// Keeps the DEPTH lowest-energy candidates sorted by ascending energy,
// with optional dedup, clear, registered readout and saturating count.
import search_pkg::*;

module optimum_sequence_topk #(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = 20,
  parameter int DEPTH     = 4,
  parameter int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int DEDUP     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEQ_WIDTH-1:0] i_seq,
  input  logic [E_WIDTH-1:0]   i_e,
  input  logic                 i_valid,
  input  logic                 i_clear,
  input  logic [IDX_WIDTH-1:0] i_rd_idx,
  input  logic                 i_rd_en,
  output logic [SEQ_WIDTH-1:0] o_rd_seq,
  output logic [E_WIDTH-1:0]   o_rd_e,
  output logic                 o_rd_slot_valid,
  output logic                 o_rd_ack,
  output logic [SEQ_WIDTH-1:0] o_best_seq,
  output logic [E_WIDTH-1:0]   o_best_e,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_full
);

  entry_t             w_cand;
  entry_t             w_slot [DEPTH];
  entry_t             w_left [DEPTH];
  entry_t             w_rd;
  logic [DEPTH-1:0]   w_better;
  logic [DEPTH-1:0]   w_lbetter;
  logic [DEPTH-1:0]   w_match;
  logic               w_dup;
  logic               w_load;

  logic [SEQ_WIDTH-1:0] r_rd_seq;
  logic [E_WIDTH-1:0]   r_rd_e;
  logic                 r_rd_sv;
  logic                 r_rd_ack;
  logic [CNT_WIDTH-1:0] r_cnt;

  always_comb begin
    w_cand       = ENTRY_RST;
    w_cand.seq   = SEQ_MAXW'(i_seq);
    w_cand.e     = E_MAXW'(i_e);
    w_cand.valid = 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      assign w_better[g] = entry_better(w_cand, w_slot[g]);
      assign w_match[g]  = w_slot[g].valid &&
                           (w_slot[g].seq == w_cand.seq);
      if (g == 0) begin : g_head
        assign w_left[g]    = ENTRY_RST;
        assign w_lbetter[g] = 1'b0;
      end else begin : g_body
        assign w_left[g]    = w_slot[g-1];
        assign w_lbetter[g] = w_better[g-1];
      end
      topk_slot u_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (i_clear),
        .i_load        (w_load),
        .i_left_better (w_lbetter[g]),
        .i_own_better  (w_better[g]),
        .i_cand        (w_cand),
        .i_left        (w_left[g]),
        .o_q           (w_slot[g])
      );
    end
  endgenerate

  assign w_dup  = (DEDUP != 0) && (|w_match);
  assign w_load = i_valid && !i_clear && !w_dup;

  // Out-of-range indices fall through to the empty-slot value.
  always_comb begin
    w_rd = ENTRY_RST;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_rd_idx == IDX_WIDTH'(k)) begin
        w_rd = w_slot[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_seq <= '0;
      r_rd_e   <= '0;
      r_rd_sv  <= 1'b0;
      r_rd_ack <= 1'b0;
    end else begin
      r_rd_ack <= i_rd_en;
      if (i_rd_en) begin
        r_rd_seq <= SEQ_WIDTH'(w_rd.seq);
        r_rd_e   <= E_WIDTH'(w_rd.e);
        r_rd_sv  <= w_rd.valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_valid && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_rd_seq        = r_rd_seq;
  assign o_rd_e          = r_rd_e;
  assign o_rd_slot_valid = r_rd_sv;
  assign o_rd_ack        = r_rd_ack;
  assign o_best_seq      = SEQ_WIDTH'(w_slot[0].seq);
  assign o_best_e        = E_WIDTH'(w_slot[0].e);
  assign o_count         = r_cnt;
  assign o_full          = w_slot[DEPTH-1].valid;

endmodule

// File: tb/tb_optimum_sequence_topk.sv
// Scoreboard bench for optimum_sequence_topk: readouts checked by monitors,
// status outputs checked directly against hand-computed values.
module tb_optimum_sequence_topk;

  typedef struct {
    logic [7:0]  s;
    logic [19:0] e;
    logic        v;
  } exp_t;

  localparam logic [19:0] EMX = 20'hFFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  exp_t qa[$];
  exp_t qb[$];

  // DUT A: defaults
  logic [7:0]  a_seq = '0;
  logic [19:0] a_e = '0;
  logic        a_valid = 1'b0;
  logic        a_clear = 1'b0;
  logic [1:0]  a_idx = '0;
  logic        a_rden = 1'b0;
  logic [7:0]  a_rseq;
  logic [19:0] a_re;
  logic        a_rsv;
  logic        a_ack;
  logic [7:0]  a_bseq;
  logic [19:0] a_be;
  logic [15:0] a_cnt;
  logic        a_full;

  // DUT B: no dedup
  logic [7:0]  b_seq = '0;
  logic [19:0] b_e = '0;
  logic        b_valid = 1'b0;
  logic [1:0]  b_idx = '0;
  logic        b_rden = 1'b0;
  logic [7:0]  b_rseq;
  logic [19:0] b_re;
  logic        b_rsv;
  logic        b_ack;
  logic [7:0]  b_bseq;
  logic [19:0] b_be;
  logic [15:0] b_cnt;
  logic        b_full;

  // DUT C: 2-bit counter
  logic [7:0]  c_seq = '0;
  logic [19:0] c_e = '0;
  logic        c_valid = 1'b0;
  logic [7:0]  c_rseq;
  logic [19:0] c_re;
  logic        c_rsv;
  logic        c_ack;
  logic [7:0]  c_bseq;
  logic [19:0] c_be;
  logic [1:0]  c_cnt;
  logic        c_full;

  optimum_sequence_topk u_a (
    .clk(clk), .rst_n(rst_n),
    .i_seq(a_seq), .i_e(a_e), .i_valid(a_valid), .i_clear(a_clear),
    .i_rd_idx(a_idx), .i_rd_en(a_rden),
    .o_rd_seq(a_rseq), .o_rd_e(a_re), .o_rd_slot_valid(a_rsv),
    .o_rd_ack(a_ack), .o_best_seq(a_bseq), .o_best_e(a_be),
    .o_count(a_cnt), .o_full(a_full)
  );

  optimum_sequence_topk #(.DEDUP(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .i_seq(b_seq), .i_e(b_e), .i_valid(b_valid), .i_clear(1'b0),
    .i_rd_idx(b_idx), .i_rd_en(b_rden),
    .o_rd_seq(b_rseq), .o_rd_e(b_re), .o_rd_slot_valid(b_rsv),
    .o_rd_ack(b_ack), .o_best_seq(b_bseq), .o_best_e(b_be),
    .o_count(b_cnt), .o_full(b_full)
  );

  optimum_sequence_topk #(.CNT_WIDTH(2)) u_c (
    .clk(clk), .rst_n(rst_n),
    .i_seq(c_seq), .i_e(c_e), .i_valid(c_valid), .i_clear(1'b0),
    .i_rd_idx(2'd0), .i_rd_en(1'b0),
    .o_rd_seq(c_rseq), .o_rd_e(c_re), .o_rd_slot_valid(c_rsv),
    .o_rd_ack(c_ack), .o_best_seq(c_bseq), .o_best_e(c_be),
    .o_count(c_cnt), .o_full(c_full)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitors: every ack pops one expected readout.
  always @(negedge clk) begin
    exp_t x;
    if (a_ack === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_ack", 32'd1, 32'd0);
      end else begin
        x = qa.pop_front();
        chk("a_rd_seq", 32'(a_rseq), 32'(x.s));
        chk("a_rd_e", 32'(a_re), 32'(x.e));
        chk("a_rd_valid", 32'(a_rsv), 32'(x.v));
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (b_ack === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_ack", 32'd1, 32'd0);
      end else begin
        x = qb.pop_front();
        chk("b_rd_seq", 32'(b_rseq), 32'(x.s));
        chk("b_rd_e", 32'(b_re), 32'(x.e));
        chk("b_rd_valid", 32'(b_rsv), 32'(x.v));
      end
    end
  end

  task automatic a_push(input logic [7:0] s, input logic [19:0] e);
    a_seq = s; a_e = e; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic a_read(input logic [1:0] idx, input logic [7:0] s,
                        input logic [19:0] e, input logic v);
    exp_t x;
    x.s = s; x.e = e; x.v = v;
    qa.push_back(x);
    a_idx = idx; a_rden = 1'b1;
    @(posedge clk); #1;
    a_rden = 1'b0;
  endtask

  task automatic a_clr();
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    chk("rst_best_e", 32'(a_be), 32'(EMX));
    chk("rst_best_seq", 32'(a_bseq), 32'd0);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_count", 32'(a_cnt), 32'd0);
    chk("rst_ack", 32'(a_ack), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) a_read(2'(i), 8'h00, EMX, 1'b0);

    // Dedup off: both copies kept, lower energy first
    b_seq = 8'h22; b_e = 20'd30; b_valid = 1'b1;
    @(posedge clk); #1;
    b_seq = 8'h22; b_e = 20'd5;
    @(posedge clk); #1;
    b_valid = 1'b0;
    x.s = 8'h22; x.e = 20'd5; x.v = 1'b1; qb.push_back(x);
    b_idx = 2'd0; b_rden = 1'b1;
    @(posedge clk); #1;
    x.s = 8'h22; x.e = 20'd30; x.v = 1'b1; qb.push_back(x);
    b_idx = 2'd1;
    @(posedge clk); #1;
    b_rden = 1'b0;

    // Saturating 2-bit counter
    c_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_seq = 8'(8'h10 + i); c_e = 20'(100 - i);
      @(posedge clk); #1;
      if (i == 2) begin
        settle();
        chk("c_count_3", 32'(c_cnt), 32'd3);
        @(posedge clk); #1;
      end
    end
    c_valid = 1'b0;
    settle();
    chk("c_count_sat", 32'(c_cnt), 32'd3);
    @(posedge clk); #1;

    // Five candidates, 0x33 evicted
    a_push(8'h11, 20'd50);
    a_push(8'h22, 20'd30);
    a_push(8'h33, 20'd70);
    a_push(8'h44, 20'd10);
    a_push(8'h55, 20'd40);
    settle();
    chk("fill_full", 32'(a_full), 32'd1);
    chk("fill_count", 32'(a_cnt), 32'd5);
    chk("fill_best_seq", 32'(a_bseq), 32'h44);
    chk("fill_best_e", 32'(a_be), 32'd10);
    @(posedge clk); #1;
    a_read(2'd0, 8'h44, 20'd10, 1'b1);
    a_read(2'd1, 8'h22, 20'd30, 1'b1);
    a_read(2'd2, 8'h55, 20'd40, 1'b1);
    a_read(2'd3, 8'h11, 20'd50, 1'b1);

    // Tie with last slot is not inserted
    a_push(8'h66, 20'd50);
    settle();
    chk("tie_count", 32'(a_cnt), 32'd6);
    @(posedge clk); #1;
    a_read(2'd3, 8'h11, 20'd50, 1'b1);
    a_read(2'd0, 8'h44, 20'd10, 1'b1);

    // Clear, then stable ordering of equal energies
    a_clr();
    settle();
    chk("clr_count", 32'(a_cnt), 32'd0);
    chk("clr_best_e", 32'(a_be), 32'(EMX));
    chk("clr_full", 32'(a_full), 32'd0);
    @(posedge clk); #1;
    a_push(8'h77, 20'd50);
    a_push(8'h88, 20'd50);
    a_read(2'd0, 8'h77, 20'd50, 1'b1);
    a_read(2'd1, 8'h88, 20'd50, 1'b1);
    a_read(2'd2, 8'h00, EMX, 1'b0);

    // Dedup on: lower-energy repeat dropped, still counted
    a_clr();
    a_push(8'h22, 20'd30);
    a_push(8'h22, 20'd5);
    settle();
    chk("dedup_count", 32'(a_cnt), 32'd2);
    @(posedge clk); #1;
    a_read(2'd0, 8'h22, 20'd30, 1'b1);
    a_read(2'd1, 8'h00, EMX, 1'b0);

    // Clear beats same-cycle strobe
    a_clear = 1'b1; a_seq = 8'h99; a_e = 20'd1; a_valid = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0; a_valid = 1'b0;
    settle();
    chk("clrv_count", 32'(a_cnt), 32'd0);
    chk("clrv_best_e", 32'(a_be), 32'(EMX));
    chk("clrv_best_seq", 32'(a_bseq), 32'd0);
    @(posedge clk); #1;

    // Readout sees the table before the same-edge insert
    x.s = 8'h00; x.e = EMX; x.v = 1'b0; qa.push_back(x);
    a_idx = 2'd0; a_rden = 1'b1;
    a_seq = 8'hAA; a_e = 20'd3; a_valid = 1'b1;
    @(posedge clk); #1;
    a_rden = 1'b0; a_valid = 1'b0;
    settle();
    chk("rdins_best_seq", 32'(a_bseq), 32'hAA);
    chk("rdins_best_e", 32'(a_be), 32'd3);
    @(posedge clk); #1;

    // Mid-stream async reset pulse
    a_read(2'd0, 8'hAA, 20'd3, 1'b1);
    a_seq = 8'hA1; a_e = 20'd5; a_valid = 1'b1;
    @(posedge clk); #1;
    a_seq = 8'hB1; a_e = 20'd100;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_best_e", 32'(a_be), 32'(EMX));
    chk("arst_best_seq", 32'(a_bseq), 32'd0);
    chk("arst_count", 32'(a_cnt), 32'd0);
    chk("arst_rd_seq", 32'(a_rseq), 32'd0);
    chk("arst_rd_e", 32'(a_re), 32'd0);
    chk("arst_ack", 32'(a_ack), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    a_seq = 8'hB2; a_e = 20'd200;
    @(posedge clk); #1;
    a_valid = 1'b0;
    settle();
    chk("post_best_seq", 32'(a_bseq), 32'hB1);
    chk("post_best_e", 32'(a_be), 32'd100);
    chk("post_count", 32'(a_cnt), 32'd2);
    @(posedge clk); #1;
    a_read(2'd1, 8'hB2, 20'd200, 1'b1);
    a_read(2'd2, 8'h00, EMX, 1'b0);

    repeat (3) @(posedge clk);
    settle();
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
